memory_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the Instruction Fetch stage (IF requester) and the Memory stage (MEM requester).
- Sequences each access over a fixed memory latency and returns read data to the owning requester.
- Drives per-requester stall signals that the pipeline registers use to hold.
- MEM has priority by default; a starvation guard guarantees that fetch makes forward progress.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_latency_timer.sv | 29 ++
 rtl/memory_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the IF/MEM memory port arbiter: FSM states, owner and access width codes.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    // Same encoding as the pipeline's R_Width/W_Width fields.
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10
    } width_e;

endpackage

// File: rtl/arb_latency_timer.sv
// Loadable down-counter that paces one memory access; done marks the last wait cycle.
module arb_latency_timer #(
    parameter int MEM_LATENCY = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MEM_LATENCY - 1);
        end else if (dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single unified memory port between fetch (IF) and data (MEM) requesters.
// Optional ARB_PERF_COUNTERS_EN adds saturating per-requester stall-cycle counters.
module memory_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic [DATA_W-1:0] IF_RData,
    output logic              IF_Ready,
    output logic              IF_Stall,
    input  logic              MEM_Req,
    input  logic              MEM_WE,
    input  logic [1:0]        MEM_Width,
    input  logic [ADDR_W-1:0] MEM_Addr,
    input  logic [DATA_W-1:0] MEM_WData,
    output logic [DATA_W-1:0] MEM_RData,
    output logic              MEM_Ready,
    output logic              MEM_Stall,
`ifdef ARB_PERF_COUNTERS_EN
    output logic [31:0]       IF_WaitCycles,
    output logic [31:0]       MEM_WaitCycles,
`endif
    output logic              Mem_Enable,
    output logic              Mem_WE,
    output logic [1:0]        Mem_Width,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic [STARVE_W-1:0] starve_q;
    logic [ADDR_W-1:0]   addr_q;
    width_e              width_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;

    logic arb_point, grant, pick_if;
    logic timer_load, timer_dec, timer_done, capture;

    // Arbitration happens when idle and on the completion cycle, allowing back-to-back grants.
    assign arb_point = (state_q == IDLE) || (state_q == DONE);
    assign grant     = arb_point && (IF_Req || MEM_Req);
    assign pick_if   = IF_Req && (!MEM_Req || starve_q == STARVE_W'(STARVE_LIMIT));

    assign IF_Stall  = IF_Req && !IF_Ready;
    assign MEM_Stall = MEM_Req && !MEM_Ready;

    assign Mem_Addr  = addr_q;
    assign Mem_Width = width_q;
    assign Mem_WE    = we_q;
    assign Mem_WData = wdata_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = (MEM_LATENCY == 1) ? DONE : WAIT;
            WAIT:    if (timer_done) state_d = DONE;
            DONE:    state_d = grant ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Mem_Enable = 1'b0;
        IF_Ready   = 1'b0;
        MEM_Ready  = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        capture    = 1'b0;
        case (state_q)
            ISSUE: begin
                Mem_Enable = 1'b1;
                timer_load = 1'b1;
                capture    = (MEM_LATENCY == 1);
            end
            WAIT: begin
                timer_dec = 1'b1;
                capture   = timer_done;
            end
            DONE: begin
                IF_Ready  = (owner_q == OWNER_IF);
                MEM_Ready = (owner_q == OWNER_MEM);
            end
            default: ;
        endcase
    end

    // Latched request fields drive the memory for the whole transaction; later input changes are ignored.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            owner_q <= OWNER_IF;
            addr_q  <= '0;
            width_q <= WIDTH_BYTE;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant) begin
            if (pick_if) begin
                owner_q <= OWNER_IF;
                addr_q  <= IF_Addr;
                width_q <= WIDTH_WORD;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end else begin
                owner_q <= OWNER_MEM;
                addr_q  <= MEM_Addr;
                width_q <= width_e'(MEM_Width);
                we_q    <= MEM_WE;
                wdata_q <= MEM_WData;
            end
        end
    end

    // Counts consecutive losses of a requesting IF; saturates so the forced IF win stays armed.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starve_q <= '0;
        end else if (grant) begin
            if (pick_if) begin
                starve_q <= '0;
            end else if (IF_Req && starve_q != STARVE_W'(STARVE_LIMIT)) begin
                starve_q <= starve_q + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            IF_RData  <= '0;
            MEM_RData <= '0;
        end else if (capture) begin
            if (owner_q == OWNER_IF) begin
                IF_RData <= Mem_RData;
            end else if (!we_q) begin
                MEM_RData <= Mem_RData;
            end
        end
    end

    arb_latency_timer #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_timer (
        .Clock(Clock),
        .Reset(Reset),
        .load (timer_load),
        .dec  (timer_dec),
        .done (timer_done)
    );

`ifdef ARB_PERF_COUNTERS_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            IF_WaitCycles  <= '0;
            MEM_WaitCycles <= '0;
        end else begin
            if (IF_Stall && IF_WaitCycles != 32'hFFFF_FFFF) begin
                IF_WaitCycles <= IF_WaitCycles + 32'd1;
            end
            if (MEM_Stall && MEM_WaitCycles != 32'hFFFF_FFFF) begin
                MEM_WaitCycles <= MEM_WaitCycles + 32'd1;
            end
        end
    end
`else
    // Without the counters, the stall outputs are the only visibility into port contention.
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter at default parameters (latency 2, starvation limit 4).
module tb_memory_port_arbiter;

    localparam int L = 2;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          issue_cyc;
        int          ready_cyc;
    } txn_t;

    logic        Clock, Reset;
    logic        IF_Req, IF_Ready, IF_Stall;
    logic [31:0] IF_Addr, IF_RData;
    logic        MEM_Req, MEM_WE, MEM_Ready, MEM_Stall;
    logic [1:0]  MEM_Width;
    logic [31:0] MEM_Addr, MEM_WData, MEM_RData;
    logic        Mem_Enable, Mem_WE;
    logic [1:0]  Mem_Width;
    logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] IF_WaitCycles, MEM_WaitCycles;
`endif

    txn_t iss_q[$];
    txn_t rdy_q[$];
    txn_t cur;
    logic busy;
    int   cyc;
    int   checks, errors;
    int   issue_count, drop_at, stall_base;
    logic hold_if, hold_mem, scramble;
    logic [31:0] exp_if_rdata, exp_mem_rdata;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C01_0004;
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    assign Mem_RData = mem_model(Mem_Addr);

    memory_port_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_RData(IF_RData),
        .IF_Ready(IF_Ready), .IF_Stall(IF_Stall),
        .MEM_Req(MEM_Req), .MEM_WE(MEM_WE), .MEM_Width(MEM_Width),
        .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData), .MEM_RData(MEM_RData),
        .MEM_Ready(MEM_Ready), .MEM_Stall(MEM_Stall),
`ifdef ARB_PERF_COUNTERS_EN
        .IF_WaitCycles(IF_WaitCycles), .MEM_WaitCycles(MEM_WaitCycles),
`endif
        .Mem_Enable(Mem_Enable), .Mem_WE(Mem_WE), .Mem_Width(Mem_Width),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_txn(input logic is_mem, input logic we, input logic [1:0] width,
                              input logic [31:0] addr, input logic [31:0] wdata, input int issue_cyc);
        txn_t t;
        t.is_mem    = is_mem;
        t.we        = we;
        t.width     = width;
        t.addr      = addr;
        t.wdata     = wdata;
        t.rdata     = mem_model(addr);
        t.issue_cyc = issue_cyc;
        t.ready_cyc = issue_cyc + L;
        iss_q.push_back(t);
        rdy_q.push_back(t);
    endtask

    // One cycle: observe at the falling edge, score issues and completions, then act as the requesters.
    task automatic tick();
        txn_t t;
        @(negedge Clock);
        if (Mem_Enable) begin
            if (iss_q.size() == 0) begin
                check("unexpected_issue", {31'd0, Mem_Enable}, 32'd0);
            end else begin
                t = iss_q.pop_front();
                check("issue_cycle", cyc, t.issue_cyc);
                check("issue_addr", Mem_Addr, t.addr);
                check("issue_we", {31'd0, Mem_WE}, {31'd0, t.we});
                if (t.is_mem) check("issue_width", {30'd0, Mem_Width}, {30'd0, t.width});
                if (t.we) check("issue_wdata", Mem_WData, t.wdata);
                cur  = t;
                busy = 1'b1;
                issue_count++;
            end
        end else if (busy) begin
            check("held_addr", Mem_Addr, cur.addr);
            check("held_we", {31'd0, Mem_WE}, {31'd0, cur.we});
        end
        if (stall_base >= 0 && cyc > stall_base && cyc <= stall_base + 6) begin
            check("if_stall", {31'd0, IF_Stall}, {31'd0, (cyc <= stall_base + 5)});
        end
        if (IF_Ready || MEM_Ready) begin
            if (rdy_q.size() == 0) begin
                check("unexpected_ready", {30'd0, IF_Ready, MEM_Ready}, 32'd0);
            end else begin
                t = rdy_q.pop_front();
                check("ready_owner", {30'd0, IF_Ready, MEM_Ready}, t.is_mem ? 32'd1 : 32'd2);
                check("ready_cycle", cyc, t.ready_cyc);
                if (!t.is_mem) exp_if_rdata = t.rdata;
                else if (!t.we) exp_mem_rdata = t.rdata;
                check("if_rdata", IF_RData, exp_if_rdata);
                check("mem_rdata", MEM_RData, exp_mem_rdata);
                busy = 1'b0;
            end
        end
        if (IF_Ready) begin
            if (hold_if) IF_Addr = IF_Addr + 32'd4;
            else IF_Req = 1'b0;
        end
        if (MEM_Ready) begin
            if (hold_mem) MEM_Addr = MEM_Addr + 32'd4;
            else MEM_Req = 1'b0;
        end
        if (Mem_Enable && scramble) begin
            MEM_Addr  = 32'hFFFF_FFF0;
            MEM_WData = 32'h0;
            MEM_WE    = 1'b0;
            MEM_Width = 2'b00;
        end
        if (drop_at > 0 && issue_count == drop_at) begin
            IF_Req   = 1'b0;
            MEM_Req  = 1'b0;
            hold_if  = 1'b0;
            hold_mem = 1'b0;
            drop_at  = 0;
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((iss_q.size() != 0 || rdy_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("timeout_pending", rdy_q.size(), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        int b;
        checks = 0; errors = 0; issue_count = 0; drop_at = 0; stall_base = -1;
        busy = 1'b0; hold_if = 1'b0; hold_mem = 1'b0; scramble = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0;
        Reset = 1'b1;
        IF_Req = 1'b1; IF_Addr = 32'h40;
        MEM_Req = 1'b1; MEM_WE = 1'b0; MEM_Width = 2'b10; MEM_Addr = 32'h200; MEM_WData = '0;

        // Reset with both requests raised
        repeat (2) @(negedge Clock);
        check("rst_mem_enable", {31'd0, Mem_Enable}, 32'd0);
        check("rst_if_ready", {31'd0, IF_Ready}, 32'd0);
        check("rst_mem_ready", {31'd0, MEM_Ready}, 32'd0);
        check("rst_if_rdata", IF_RData, 32'd0);
        check("rst_mem_rdata", MEM_RData, 32'd0);
        check("rst_if_stall", {31'd0, IF_Stall}, 32'd1);
        check("rst_mem_stall", {31'd0, MEM_Stall}, 32'd1);
        IF_Req = 1'b0; MEM_Req = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) tick();

        // IF alone
        b = cyc;
        IF_Addr = 32'h40; IF_Req = 1'b1;
        expect_txn(1'b0, 1'b0, 2'b10, 32'h40, 32'h0, b + 1);
        run(20);

        // Simultaneous: MEM first, then IF
        b = cyc;
        IF_Addr = 32'h44; IF_Req = 1'b1;
        MEM_Addr = 32'h200; MEM_WE = 1'b0; MEM_Width = 2'b00; MEM_Req = 1'b1;
        #1 check("if_stall_c0", {31'd0, IF_Stall}, 32'd1);
        stall_base = b;
        expect_txn(1'b1, 1'b0, 2'b00, 32'h200, 32'h0, b + 1);
        expect_txn(1'b0, 1'b0, 2'b10, 32'h44, 32'h0, b + 1 + (L + 1));
        run(30);
        stall_base = -1;

        // Starvation guard: both held, MEM x4, IF, MEM
        b = cyc;
        IF_Addr = 32'h80; MEM_Addr = 32'h300; MEM_Width = 2'b01;
        hold_if = 1'b1; hold_mem = 1'b1;
        IF_Req = 1'b1; MEM_Req = 1'b1;
        drop_at = issue_count + 6;
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'b1, 1'b0, 2'b01, 32'h300 + 32'(4 * k), 32'h0, b + 1 + k * (L + 1));
        end
        expect_txn(1'b0, 1'b0, 2'b10, 32'h80, 32'h0, b + 1 + 4 * (L + 1));
        expect_txn(1'b1, 1'b0, 2'b01, 32'h310, 32'h0, b + 1 + 5 * (L + 1));
        run(60);

        // Word write; request fields scrambled after the grant
        b = cyc;
        MEM_WE = 1'b1; MEM_Width = 2'b10; MEM_Addr = 32'h100; MEM_WData = 32'hDEAD_BEEF;
        MEM_Req = 1'b1; scramble = 1'b1;
        expect_txn(1'b1, 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF, b + 1);
        run(20);
        scramble = 1'b0;
        MEM_WE = 1'b0;

        // Reset during the WAIT cycle
        b = cyc;
        IF_Addr = 32'h48; IF_Req = 1'b1;
        expect_txn(1'b0, 1'b0, 2'b10, 32'h48, 32'h0, b + 1);
        repeat (2) tick();
        Reset = 1'b1;
        #1;
        check("midrst_enable", {31'd0, Mem_Enable}, 32'd0);
        check("midrst_addr", Mem_Addr, 32'd0);
        check("midrst_we", {31'd0, Mem_WE}, 32'd0);
        check("midrst_width", {30'd0, Mem_Width}, 32'd0);
        check("midrst_wdata", Mem_WData, 32'd0);
        check("midrst_if_rdata", IF_RData, 32'd0);
        check("midrst_mem_rdata", MEM_RData, 32'd0);
        iss_q.delete();
        rdy_q.delete();
        busy = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0;
        IF_Req = 1'b0; MEM_Req = 1'b0;
        tick();
        Reset = 1'b0;
        repeat (5) tick();

        // Fresh request after reset
        b = cyc;
        MEM_Addr = 32'h204; MEM_Width = 2'b01; MEM_WE = 1'b0; MEM_Req = 1'b1;
        expect_txn(1'b1, 1'b0, 2'b01, 32'h204, 32'h0, b + 1);
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
